reorder9_ctrl: RTL and testbench
================================

# reorder9_ctrl

Sequencer for the 9-point reorder stage of the PUSCH FFT. It collects upstream samples, which may arrive with gaps, into a ping-pong 2×9 staging buffer and issues gap-free 9-cycle write bursts to the reorder stage. It then waits out the stage's 9-cycle read-out and recovery cycle, and counts blocks per transform symbol. It sits between the sample source and the reorder stage.

## Interface
- WIDTH, 18, sample component width (signed)
- NBLK_W, 8, width of block-count configuration
- TO_CYC, 16, watchdog limit in S_WAIT (cycles)

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; latches cfg_nblk, begins a symbol
- cfg_nblk  in  NBLK_W  blocks of 9 samples per symbol; 0 is treated as 1
- s_re, s_im  in  WIDTH  upstream sample
- s_valid  in  1  upstream valid
- s_ready  out  1  upstream ready; transfer on s_valid&&s_ready
- ro_di_re, ro_di_im  out  WIDTH  samples to reorder stage (registered)
- ro_di_en  out  1  reorder write enable (registered)
- ro_do_en  in  1  reorder stage output-valid
- busy  out  1  symbol in progress
- sym_done  out  1  one-cycle pulse after last block drained
- err  out  1  sticky protocol/timeout error; cleared by rst or start

## Operation
- Reset: all outputs 0, both banks empty, FSM S_IDLE, counters 0.
- Fill side is independent of the FSM. The write bank accepts a sample whenever `busy && !bank_full[wr_bank]`. After the 9th sample, the bank is marked full and wr_bank toggles.
- Samples accepted while !busy: none (s_ready=0).
- FSM states:
  - S_IDLE: if busy and bank_full[rd_bank], go to S_BURST.
  - S_BURST: 9 cycles, reading rd_bank entries 0..8 in arrival order with ro_di_en=1. On the 9th cycle, clear bank_full[rd_bank], toggle rd_bank, and go to S_WAIT.
  - S_WAIT: count ro_do_en cycles. At 9, go to S_GAP. If TO_CYC cycles elapse with fewer than 9, set err and go to S_ABORT.
  - S_GAP: one cycle with ro_di_en=0, to cover the reorder stage's counter-clear cycle. blk_cnt++. If blk_cnt reaches cfg_nblk, pulse sym_done, drop busy, and go to S_IDLE. Else, if bank_full[rd_bank], go to S_BURST; otherwise go to S_IDLE.
  - S_ABORT: clear both banks and busy, then go to S_IDLE; no sym_done.
- ro_do_en seen in any state other than S_WAIT sets err; the FSM does not change state.
- start while busy is ignored. start while !busy clears err, blk_cnt and banks, and latches cfg_nblk.
- ro_di_re/ro_di_im are 0 whenever ro_di_en=0.

## Timing
- ro_di_en is always exactly 9 consecutive high cycles, never split.
- Burst in cycles t..t+8 → reorder ro_do_en is expected in t+10..t+18. S_GAP falls at t+19, and the next burst can start at t+20. Minimum block period is 20 cycles.
- First burst starts 2 cycles after the 9th sample handshake: full flag registered in the first cycle, S_BURST in the second.
- Throughput: upstream at 1 sample/cycle is throttled. s_ready falls when both banks are full.
- A simultaneous fill-complete on one bank and burst-end on the other is legal; the flags are independent.
- rst mid-burst: ro_di_en is 0 on the next cycle. The reorder stage shares the same rst.

## Structure
- A shared package fft_pkg holds the state enum, the constant BLK=9, and TO_CYC.
- One sub-module, rc_pingpong_buf: 2×9×(2·WIDTH) storage with the wr/rd bank pointers and full flags. The FSM and counters stay in reorder9_ctrl.

## Test plan
- Single block: start with cfg_nblk=1, then 9 contiguous samples 1..9. Expect ro_di_en high for 9 cycles carrying 1..9. Drive ro_do_en from a real reorder9 model and check it outputs 1,4,7,2,5,8,3,6,9. Expect sym_done at t+19 and busy low afterward.
- Gapped input: cfg_nblk=2, with s_valid toggling every other cycle. Each burst must still be 9 contiguous cycles, and bursts must be spaced ≥20 cycles apart.
- Backpressure: cfg_nblk=4 with s_valid held high. s_ready must drop after 18 accepts and reopen as banks drain. All 36 samples arrive in order; sym_done fires once.
- Watchdog: suppress ro_do_en after a burst. err is set TO_CYC cycles after entering S_WAIT, busy drops, and there is no sym_done.
- Spurious ro_do_en while in S_IDLE → err is set, and a subsequent start clears it.
- rst asserted in the middle of S_BURST (cycle 4) → next cycle all outputs are 0, s_ready=0, and a fresh start completes normally.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: constants and types for the 9-point reorder sequencer.
//   BLK        samples per reorder block
//   TO_CYC_DEF default watchdog limit (cycles) for the read-out wait
//   IDX_W      width of in-block index counters
//   state_t    sequencer FSM states
package fft_pkg;

  localparam int unsigned BLK        = 9;
  localparam int unsigned TO_CYC_DEF = 16;
  localparam int unsigned IDX_W      = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BURST,
    S_WAIT,
    S_GAP,
    S_ABORT
  } state_t;

endpackage

// File: rtl/reorder9_ctrl_if.sv
// reorder9_ctrl_if: upstream sample stream (valid/ready).
//   s_re, s_im  signed sample components
//   s_valid     source has a sample
//   s_ready     sink accepts; transfer on s_valid && s_ready
// master = sample source, slave = reorder9_ctrl.
interface reorder9_ctrl_if #(
  parameter int unsigned WIDTH = 18
) ();

  logic signed [WIDTH-1:0] s_re;
  logic signed [WIDTH-1:0] s_im;
  logic                    s_valid;
  logic                    s_ready;

  modport master (
    output s_re,
    output s_im,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_re,
    input  s_im,
    input  s_valid,
    output s_ready
  );

endinterface

// File: rtl/rc_pingpong_buf.sv
// rc_pingpong_buf: 2 x BLK ping-pong staging buffer.
//   clk, rst    clock, synchronous active-high reset
//   clr         empties both banks and resets pointers
//   wr_en       write one sample into the current write bank
//   wr_data     packed {re, im} sample
//   wr_ready    current write bank is not full
//   rd_idx      entry of the current read bank to present on rd_data
//   rd_release  read bank consumed: clear its full flag, move to other bank
//   rd_full     current read bank is full
//   rd_data     combinational read of rd_idx in the read bank
module rc_pingpong_buf
  import fft_pkg::*;
#(
  parameter int unsigned DW = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [DW-1:0]    wr_data,
  output logic             wr_ready,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic             rd_release,
  output logic             rd_full,
  output logic [DW-1:0]    rd_data
);

  logic [DW-1:0]    mem [2][BLK];
  logic             wr_bank;
  logic             rd_bank;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       bank_full;
  logic             wr_acc;

  assign wr_ready = !bank_full[wr_bank];
  assign rd_full  = bank_full[rd_bank];
  assign rd_data  = mem[rd_bank][rd_idx];
  assign wr_acc   = wr_en && !bank_full[wr_bank];

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_bank][wr_idx] <= wr_data;
    end
  end

  // Fill and drain touch different banks, so a fill-complete and a
  // release landing in the same cycle update independent flag bits.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_idx    <= '0;
      bank_full <= '0;
    end else begin
      if (wr_acc) begin
        if (wr_idx == IDX_W'(BLK - 1)) begin
          bank_full[wr_bank] <= 1'b1;
          wr_bank            <= !wr_bank;
          wr_idx             <= '0;
        end else begin
          wr_idx <= wr_idx + IDX_W'(1);
        end
      end
      if (rd_release) begin
        bank_full[rd_bank] <= 1'b0;
        rd_bank            <= !rd_bank;
      end
    end
  end

endmodule

// File: rtl/reorder9_ctrl.sv
// reorder9_ctrl: sequencer for the 9-point reorder stage.
// Collects upstream samples (gaps allowed) into a ping-pong buffer and
// issues gap-free 9-cycle write bursts, waits out the stage read-out,
// and counts blocks per symbol.
//   clk, rst          clock, synchronous active-high reset
//   start             begins a symbol (ignored while busy), latches cfg_nblk
//   cfg_nblk          blocks per symbol, 0 treated as 1
//   up                upstream sample stream (slave side)
//   ro_di_re/im       samples to reorder stage, 0 when ro_di_en is low
//   ro_di_en          reorder write enable
//   ro_do_en          reorder output-valid
//   busy              symbol in progress
//   sym_done          one-cycle pulse after the last block drained
//   err               sticky protocol/timeout error, cleared by rst or start
module reorder9_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH  = 18,
  parameter int unsigned NBLK_W = 8,
  parameter int unsigned TO_CYC = TO_CYC_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NBLK_W-1:0]       cfg_nblk,
  reorder9_ctrl_if.slave          up,
  output logic signed [WIDTH-1:0] ro_di_re,
  output logic signed [WIDTH-1:0] ro_di_im,
  output logic                    ro_di_en,
  input  logic                    ro_do_en,
  output logic                    busy,
  output logic                    sym_done,
  output logic                    err
);

  localparam int unsigned WC_W = $clog2(TO_CYC + 1);

  state_t             state;
  logic [IDX_W-1:0]   rd_idx;
  logic [IDX_W-1:0]   dcnt;
  logic [WC_W-1:0]    wcnt;
  logic [NBLK_W-1:0]  blk_cnt;
  logic [NBLK_W-1:0]  nblk;

  logic               clr_req;
  logic               buf_clr;
  logic               wr_en;
  logic               wr_ready;
  logic               rd_full;
  logic               rd_release;
  logic [IDX_W-1:0]   rd_addr;
  logic [2*WIDTH-1:0] rd_data;
  logic               last_blk;

  assign clr_req    = start && !busy;
  assign buf_clr    = clr_req || (state == S_ABORT);
  assign up.s_ready = busy && wr_ready;
  assign wr_en      = up.s_valid && up.s_ready;
  assign rd_release = (state == S_BURST) && (rd_idx == IDX_W'(BLK - 1));
  assign last_blk   = (blk_cnt == nblk - NBLK_W'(1));

  // Output data is registered, so the buffer is addressed one entry
  // ahead of what ro_di_* currently shows.
  always_comb begin
    rd_addr = '0;
    if (state == S_BURST && rd_idx != IDX_W'(BLK - 1)) begin
      rd_addr = rd_idx + IDX_W'(1);
    end
  end

  rc_pingpong_buf #(
    .DW (2 * WIDTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .clr        (buf_clr),
    .wr_en      (wr_en),
    .wr_data    ({up.s_re, up.s_im}),
    .wr_ready   (wr_ready),
    .rd_idx     (rd_addr),
    .rd_release (rd_release),
    .rd_full    (rd_full),
    .rd_data    (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rd_idx   <= '0;
      dcnt     <= '0;
      wcnt     <= '0;
      blk_cnt  <= '0;
      nblk     <= '0;
      ro_di_re <= '0;
      ro_di_im <= '0;
      ro_di_en <= 1'b0;
      busy     <= 1'b0;
      sym_done <= 1'b0;
      err      <= 1'b0;
    end else begin
      sym_done <= 1'b0;
      ro_di_en <= 1'b0;
      ro_di_re <= '0;
      ro_di_im <= '0;

      if (clr_req) begin
        err     <= 1'b0;
        blk_cnt <= '0;
        nblk    <= (cfg_nblk == '0) ? NBLK_W'(1) : cfg_nblk;
        busy    <= 1'b1;
      end

      if (ro_do_en && state != S_WAIT) begin
        err <= 1'b1;
      end

      unique case (state)
        S_IDLE: begin
          if (busy && rd_full) begin
            state                <= S_BURST;
            rd_idx               <= '0;
            ro_di_en             <= 1'b1;
            {ro_di_re, ro_di_im} <= rd_data;
          end
        end

        S_BURST: begin
          if (rd_idx == IDX_W'(BLK - 1)) begin
            state <= S_WAIT;
            dcnt  <= '0;
            wcnt  <= '0;
          end else begin
            rd_idx               <= rd_idx + IDX_W'(1);
            ro_di_en             <= 1'b1;
            {ro_di_re, ro_di_im} <= rd_data;
          end
        end

        S_WAIT: begin
          // A 9th output-valid in the final watchdog cycle still counts.
          if (ro_do_en && dcnt == IDX_W'(BLK - 1)) begin
            state    <= S_GAP;
            sym_done <= last_blk;
          end else begin
            if (ro_do_en) begin
              dcnt <= dcnt + IDX_W'(1);
            end
            if (wcnt == WC_W'(TO_CYC - 1)) begin
              err   <= 1'b1;
              state <= S_ABORT;
            end else begin
              wcnt <= wcnt + WC_W'(1);
            end
          end
        end

        S_GAP: begin
          blk_cnt <= blk_cnt + NBLK_W'(1);
          if (last_blk) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (rd_full) begin
            state                <= S_BURST;
            rd_idx               <= '0;
            ro_di_en             <= 1'b1;
            {ro_di_re, ro_di_im} <= rd_data;
          end else begin
            state <= S_IDLE;
          end
        end

        S_ABORT: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reorder9_ctrl.sv
// tb_reorder9_ctrl: self-checking bench for reorder9_ctrl with a
// behavioural 9-point reorder stage (writes at t..t+8, output-valid at
// t+10..t+18 in order 0,3,6,1,4,7,2,5,8).
module tb_reorder9_ctrl;

  localparam int WIDTH  = 18;
  localparam int NBLK_W = 8;
  localparam int TO_CYC = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [NBLK_W-1:0]       cfg_nblk;
  logic signed [WIDTH-1:0] ro_di_re;
  logic signed [WIDTH-1:0] ro_di_im;
  logic                    ro_di_en;
  logic                    ro_do_en;
  logic                    busy;
  logic                    sym_done;
  logic                    err;
  logic                    mdl_do_en   = 1'b0;
  logic                    force_do_en = 1'b0;

  assign ro_do_en = mdl_do_en | force_do_en;

  reorder9_ctrl_if #(.WIDTH(WIDTH)) up ();

  reorder9_ctrl #(
    .WIDTH  (WIDTH),
    .NBLK_W (NBLK_W),
    .TO_CYC (TO_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cfg_nblk (cfg_nblk),
    .up       (up.slave),
    .ro_di_re (ro_di_re),
    .ro_di_im (ro_di_im),
    .ro_di_en (ro_di_en),
    .ro_do_en (ro_do_en),
    .busy     (busy),
    .sym_done (sym_done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Observation logs filled by the monitor / reorder model.
  int          burst_start_q[$];
  int          burst_len_q[$];
  int          sd_q[$];
  logic [35:0] di_q[$];
  logic [35:0] exp_q[$];
  logic [35:0] ro_out_q[$];
  int          zero_viol = 0;
  int          last_hs   = 0;
  int          drop_at   = -1;
  bit          mute      = 1'b0;

  int          run = 0;
  logic [35:0] mwbuf [9];
  logic [35:0] mobuf [9];
  int          mw_n = 0;
  int          mo_start = 0;
  bit          mo_pending = 1'b0;
  int          k;

  // Monitor plus reorder-stage model; acts 1 time unit after each edge.
  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      mdl_do_en = 1'b0;
      if (rst) begin
        run        = 0;
        mw_n       = 0;
        mo_pending = 1'b0;
      end else begin
        if (ro_di_en) begin
          if (run == 0) burst_start_q.push_back(cyc);
          run++;
          di_q.push_back({ro_di_re, ro_di_im});
          if (mw_n < 9) mwbuf[mw_n] = {ro_di_re, ro_di_im};
          mw_n++;
          if (mw_n == 9) begin
            mobuf      = mwbuf;
            mw_n       = 0;
            mo_start   = cyc + 2;
            mo_pending = 1'b1;
          end
        end else begin
          if (run != 0) burst_len_q.push_back(run);
          run = 0;
          if (ro_di_re !== '0 || ro_di_im !== '0) zero_viol++;
        end
        if (sym_done) sd_q.push_back(cyc);
        if (mo_pending && cyc >= mo_start) begin
          k = cyc - mo_start;
          if (!mute) begin
            mdl_do_en = 1'b1;
            ro_out_q.push_back(mobuf[(k % 3) * 3 + k / 3]);
          end
          if (k == 8) mo_pending = 1'b0;
        end
      end
    end
  end

  initial begin : global_timeout
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench timeout");
  end

  // ---------------- reference helpers ----------------
  function automatic int di_mismatch();
    if (di_q.size() != exp_q.size()) return 1000 + di_q.size();
    foreach (exp_q[i]) if (di_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  // Expected reorder output: within each block of 9, column-major read of
  // a 3x3 row-major fill.
  function automatic int ro_mismatch();
    int nb;
    nb = exp_q.size() / 9;
    if (ro_out_q.size() != nb * 9) return 1000 + ro_out_q.size();
    for (int b = 0; b < nb; b++)
      for (int j = 0; j < 9; j++)
        if (ro_out_q[b*9 + j] !== exp_q[b*9 + (j % 3) * 3 + j / 3]) return b*9 + j;
    return -1;
  endfunction

  function automatic int bad_bursts();
    int n = 0;
    foreach (burst_len_q[i]) if (burst_len_q[i] != 9) n++;
    return n;
  endfunction

  function automatic int min_spacing();
    int m = 1000;
    for (int i = 1; i < burst_start_q.size(); i++)
      if (burst_start_q[i] - burst_start_q[i-1] < m) m = burst_start_q[i] - burst_start_q[i-1];
    return m;
  endfunction

  function automatic int last_start();
    if (burst_start_q.size() == 0) return -1000;
    return burst_start_q[burst_start_q.size()-1];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clear_logs();
    burst_start_q.delete();
    burst_len_q.delete();
    sd_q.delete();
    di_q.delete();
    exp_q.delete();
    ro_out_q.delete();
    zero_viol = 0;
    drop_at   = -1;
  endtask

  task automatic do_start(input int n);
    @(negedge clk);
    start    = 1'b1;
    cfg_nblk = NBLK_W'(n);
    @(negedge clk);
    start    = 1'b0;
  endtask

  // mode 0: valid always, 1: valid every other cycle, 2: random valid.
  task automatic send(input int n, input int mode, input bit seq, output int got);
    int          sent  = 0;
    int          guard = 0;
    bit          have  = 1'b0;
    bit          v;
    logic [35:0] cur;
    logic [31:0] r;
    while (sent < n && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (!have) begin
        if (seq) begin
          cur[35:18] = 18'(sent + 1);
          cur[17:0]  = 18'(-(sent + 1));
        end else begin
          r = $urandom();
          cur[35:18] = r[17:0];
          r = $urandom();
          cur[17:0] = r[17:0];
        end
        have = 1'b1;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (guard % 2) == 1;
        default: v = 1'($urandom_range(0, 1));
      endcase
      up.s_valid = v;
      up.s_re    = cur[35:18];
      up.s_im    = cur[17:0];
      if (v && up.s_ready) begin
        exp_q.push_back(cur);
        sent++;
        last_hs = cyc;
        have    = 1'b0;
      end else if (v && !up.s_ready && drop_at < 0) begin
        drop_at = sent;
      end
    end
    @(negedge clk);
    up.s_valid = 1'b0;
    got = sent;
  endtask

  task automatic wait_idle(output bit ok, output int at);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < 400; i++) begin
      if (!busy) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cfg_nblk = '0;
    up.s_valid = 1'b0; up.s_re = '0; up.s_im = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ro_di_en, busy, sym_done, err, up.s_ready} !== 5'b0)
      $display("FAIL reset_ctrl: got %b, expected 00000", {ro_di_en, busy, sym_done, err, up.s_ready});
    else n_pass++;
    n_checks++;
    if (ro_di_re !== '0 || ro_di_im !== '0)
      $display("FAIL reset_data: got %0d/%0d, expected 0/0", ro_di_re, ro_di_im);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_block();
    int got, idle_at, t;
    bit ok;
    int exp_ro[9] = '{1, 4, 7, 2, 5, 8, 3, 6, 9};
    clear_logs();
    do_start(1);
    send(9, 0, 1'b1, got);
    wait_idle(ok, idle_at);
    t = last_start();
    n_checks++;
    if (!ok || burst_len_q.size() != 1 || bad_bursts() != 0)
      $display("FAIL single_burst: got %0d bursts ok=%0d, expected 1 burst of 9", burst_len_q.size(), ok);
    else n_pass++;
    n_checks++;
    if (t !== last_hs + 2) $display("FAIL single_latency: got start %0d, expected %0d", t, last_hs + 2);
    else n_pass++;
    n_checks++;
    if (di_mismatch() != -1) $display("FAIL single_data: got mismatch at %0d, expected none", di_mismatch());
    else n_pass++;
    for (int j = 0; j < 9; j++) begin
      n_checks++;
      if (ro_out_q.size() <= j || int'(signed'(ro_out_q[j][35:18])) !== exp_ro[j]) begin
        $display("FAIL single_reorder[%0d]: got %0d, expected %0d", j,
                 (ro_out_q.size() > j) ? int'(signed'(ro_out_q[j][35:18])) : -1, exp_ro[j]);
      end else n_pass++;
    end
    n_checks++;
    if (sd_q.size() != 1 || sd_q[0] != t + 19)
      $display("FAIL single_sym_done: got %0d pulses first at %0d, expected 1 at %0d",
               sd_q.size(), (sd_q.size() > 0) ? sd_q[0] : -1, t + 19);
    else n_pass++;
    n_checks++;
    if (idle_at !== t + 20) $display("FAIL single_busy_low: got %0d, expected %0d", idle_at, t + 20);
    else n_pass++;
    n_checks++;
    if (zero_viol != 0 || err !== 1'b0)
      $display("FAIL single_idle_zero: got viol=%0d err=%0b, expected 0/0", zero_viol, err);
    else n_pass++;
  endtask

  task automatic test_gapped();
    int got, idle_at;
    bit ok;
    clear_logs();
    do_start(2);
    send(18, 1, 1'b0, got);
    wait_idle(ok, idle_at);
    n_checks++;
    if (!ok || burst_len_q.size() != 2 || bad_bursts() != 0)
      $display("FAIL gapped_bursts: got %0d bursts bad=%0d, expected 2 of 9", burst_len_q.size(), bad_bursts());
    else n_pass++;
    n_checks++;
    if (min_spacing() < 20) $display("FAIL gapped_spacing: got %0d, expected >=20", min_spacing());
    else n_pass++;
    n_checks++;
    if (di_mismatch() != -1 || ro_mismatch() != -1)
      $display("FAIL gapped_data: got di=%0d ro=%0d, expected -1/-1", di_mismatch(), ro_mismatch());
    else n_pass++;
    n_checks++;
    if (sd_q.size() != 1 || sd_q[0] != last_start() + 19)
      $display("FAIL gapped_sym_done: got %0d pulses, expected 1 at %0d", sd_q.size(), last_start() + 19);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int got, idle_at;
    bit ok;
    clear_logs();
    do_start(4);
    send(36, 0, 1'b0, got);
    wait_idle(ok, idle_at);
    n_checks++;
    if (drop_at !== 18) $display("FAIL bp_ready_drop: got %0d accepts, expected 18", drop_at);
    else n_pass++;
    n_checks++;
    if (got !== 36 || !ok) $display("FAIL bp_all_accepted: got %0d ok=%0d, expected 36", got, ok);
    else n_pass++;
    n_checks++;
    if (burst_len_q.size() != 4 || bad_bursts() != 0 || min_spacing() < 20)
      $display("FAIL bp_bursts: got %0d bursts spacing %0d, expected 4 spacing>=20", burst_len_q.size(), min_spacing());
    else n_pass++;
    n_checks++;
    if (di_mismatch() != -1 || ro_mismatch() != -1)
      $display("FAIL bp_data: got di=%0d ro=%0d, expected -1/-1", di_mismatch(), ro_mismatch());
    else n_pass++;
    n_checks++;
    if (sd_q.size() != 1) $display("FAIL bp_sym_done: got %0d pulses, expected 1", sd_q.size());
    else n_pass++;
  endtask

  task automatic test_watchdog();
    int got, idle_at, err_at;
    bit ok;
    clear_logs();
    do_start(1);
    mute = 1'b1;
    send(9, 0, 1'b0, got);
    err_at = -1;
    for (int i = 0; i < 200; i++) begin
      if (err) begin
        err_at = cyc;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (err_at !== last_start() + 9 + TO_CYC)
      $display("FAIL wd_err_time: got %0d, expected %0d", err_at, last_start() + 9 + TO_CYC);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL wd_busy: got %0b, expected 0", busy);
    else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++;
    if (sd_q.size() != 0 || err !== 1'b1)
      $display("FAIL wd_no_done: got %0d pulses err=%0b, expected 0 pulses err=1", sd_q.size(), err);
    else n_pass++;
    mute = 1'b0;
    clear_logs();
    do_start(1);
    n_checks++;
    if (err !== 1'b0) $display("FAIL wd_start_clears: got %0b, expected 0", err);
    else n_pass++;
    send(9, 2, 1'b0, got);
    wait_idle(ok, idle_at);
    n_checks++;
    if (!ok || sd_q.size() != 1 || di_mismatch() != -1)
      $display("FAIL wd_recover: got ok=%0d pulses=%0d di=%0d, expected 1/1/-1", ok, sd_q.size(), di_mismatch());
    else n_pass++;
  endtask

  task automatic test_spurious();
    int got, idle_at;
    bit ok;
    clear_logs();
    @(negedge clk);
    force_do_en = 1'b1;
    @(negedge clk);
    force_do_en = 1'b0;
    n_checks++;
    if ({err, busy, ro_di_en} !== 3'b100)
      $display("FAIL spurious_err: got %b, expected 100", {err, busy, ro_di_en});
    else n_pass++;
    do_start(1);
    n_checks++;
    if (err !== 1'b0) $display("FAIL spurious_clear: got %0b, expected 0", err);
    else n_pass++;
    send(9, 2, 1'b0, got);
    wait_idle(ok, idle_at);
    n_checks++;
    if (!ok || sd_q.size() != 1 || err !== 1'b0 || ro_mismatch() != -1)
      $display("FAIL spurious_after: got ok=%0d pulses=%0d err=%0b ro=%0d, expected 1/1/0/-1",
               ok, sd_q.size(), err, ro_mismatch());
    else n_pass++;
  endtask

  task automatic test_rst_mid_burst();
    int got, idle_at;
    bit ok, seen;
    clear_logs();
    do_start(1);
    send(9, 0, 1'b0, got);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (ro_di_en) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!seen) $display("FAIL rst_burst_seen: got 0, expected 1");
    else n_pass++;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ro_di_en, busy, sym_done, err, up.s_ready} !== 5'b0 || ro_di_re !== '0 || ro_di_im !== '0)
      $display("FAIL rst_mid_outputs: got %b re=%0d im=%0d, expected 00000 0 0",
               {ro_di_en, busy, sym_done, err, up.s_ready}, ro_di_re, ro_di_im);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    clear_logs();
    do_start(1);
    send(9, 2, 1'b0, got);
    wait_idle(ok, idle_at);
    n_checks++;
    if (!ok || burst_len_q.size() != 1 || bad_bursts() != 0 || sd_q.size() != 1 ||
        di_mismatch() != -1 || ro_mismatch() != -1)
      $display("FAIL rst_recover: got ok=%0d bursts=%0d pulses=%0d di=%0d, expected 1/1/1/-1",
               ok, burst_len_q.size(), sd_q.size(), di_mismatch());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int got, idle_at, cfg, eff;
    bit ok;
    for (int it = 0; it < 3; it++) begin
      cfg = (it == 0) ? 0 : int'($urandom_range(2, 3));
      eff = (cfg == 0) ? 1 : cfg;
      clear_logs();
      do_start(cfg);
      send(eff * 9, 2, 1'b0, got);
      wait_idle(ok, idle_at);
      n_checks++;
      if (!ok || burst_len_q.size() != eff || bad_bursts() != 0 || min_spacing() < 20)
        $display("FAIL b2b_bursts[%0d]: got %0d bursts spacing %0d, expected %0d spacing>=20",
                 it, burst_len_q.size(), min_spacing(), eff);
      else n_pass++;
      n_checks++;
      if (di_mismatch() != -1 || ro_mismatch() != -1 || zero_viol != 0)
        $display("FAIL b2b_data[%0d]: got di=%0d ro=%0d viol=%0d, expected -1/-1/0",
                 it, di_mismatch(), ro_mismatch(), zero_viol);
      else n_pass++;
      n_checks++;
      if (sd_q.size() != 1 || sd_q[0] != last_start() + 19)
        $display("FAIL b2b_sym_done[%0d]: got %0d pulses, expected 1 at %0d", it, sd_q.size(), last_start() + 19);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_gapped();
    test_backpressure();
    test_watchdog();
    test_spurious();
    test_rst_mid_burst();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
